// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and helpers for the in-order core pipeline.
//   reg_idx_t           : architectural register index (x0..x31)
//   rd_src_e            : source of the value written back to rd
//   NUM_ARCH_REGS       : number of architectural integer registers
//   rd_src_forwardable  : 1 when the rd value can be forwarded to a dependent
//                         instruction the cycle after its producer issues
// -----------------------------------------------------------------------------
package core_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        RD_FROM_ALU_RESULT  = 2'd0,
        RD_FROM_MEM_LOAD    = 2'd1,
        RD_FROM_NEXT_SEQ_PC = 2'd2,
        RD_FROM_CSR         = 2'd3
    } rd_src_e;

    localparam int NUM_ARCH_REGS = 32;

    function automatic logic rd_src_forwardable(input rd_src_e src);
        return (src == RD_FROM_ALU_RESULT) || (src == RD_FROM_NEXT_SEQ_PC);
    endfunction

endpackage

// File: rtl/core_scoreboard.sv
// -----------------------------------------------------------------------------
// core_scoreboard
// Register-hazard scheduler sitting between decode and execute. Every
// architectural register with an in-flight writer is marked busy; decode is
// held off on an uncovered RAW hazard, on any WAW hazard, or when the number
// of pending writers reaches MAX_INFLIGHT.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_issue_*            instruction presented by decode (valid, sources, rd)
//   o_issue_ready        combinational; issue fires on valid && ready
//   i_wb_valid, i_wb_rd  writeback retiring a register write
//   i_flush              kill all in-flight instructions
//   o_busy               per-register pending bits (bit 0 always 0)
//   o_inflight           number of pending writers
//   o_wb_err             one-cycle pulse: writeback hit a non-busy register
// -----------------------------------------------------------------------------
module core_scoreboard
    import core_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int FWD_EN       = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_issue_valid,
    input  reg_idx_t                 i_issue_rs1,
    input  logic                     i_issue_rs1_used,
    input  reg_idx_t                 i_issue_rs2,
    input  logic                     i_issue_rs2_used,
    input  logic                     i_issue_rd_we,
    input  reg_idx_t                 i_issue_rd,
    input  rd_src_e                  i_issue_rd_src,
    output logic                     o_issue_ready,
    input  logic                     i_wb_valid,
    input  reg_idx_t                 i_wb_rd,
    input  logic                     i_flush,
    output logic [NUM_ARCH_REGS-1:0] o_busy,
    output logic [3:0]               o_inflight,
    output logic                     o_wb_err
);

    localparam logic [3:0] INFLIGHT_MAX = 4'(MAX_INFLIGHT);

    logic [NUM_ARCH_REGS-1:0] busy;
    logic [NUM_ARCH_REGS-1:0] fwd_ok;
    logic [3:0]               inflight;

    logic [NUM_ARCH_REGS-1:0] wb_onehot;
    logic [NUM_ARCH_REGS-1:0] eff_busy;
    logic [NUM_ARCH_REGS-1:0] busy_nxt;
    logic [NUM_ARCH_REGS-1:0] fwd_ok_nxt;
    logic [3:0]               inflight_after_wb;
    logic [3:0]               inflight_nxt;
    logic                     wb_hit;
    logic                     wb_miss;
    logic                     raw1;
    logic                     raw2;
    logic                     waw;
    logic                     full;
    logic                     issue_ready;
    logic                     set_en;

    always_comb begin
        wb_onehot = '0;
        if (i_wb_valid) begin
            wb_onehot[i_wb_rd] = 1'b1;
        end
        // A register retiring this cycle no longer blocks the issuing instruction.
        eff_busy = busy & ~wb_onehot;

        wb_hit  = i_wb_valid && (i_wb_rd != '0) && busy[i_wb_rd];
        wb_miss = i_wb_valid && (i_wb_rd != '0) && !busy[i_wb_rd];

        raw1 = i_issue_rs1_used && (i_issue_rs1 != '0) &&
               eff_busy[i_issue_rs1] && !fwd_ok[i_issue_rs1];
        raw2 = i_issue_rs2_used && (i_issue_rs2 != '0) &&
               eff_busy[i_issue_rs2] && !fwd_ok[i_issue_rs2];
        // Forwarding covers reads only; a second writer must always wait.
        waw  = i_issue_rd_we && (i_issue_rd != '0) && eff_busy[i_issue_rd];

        inflight_after_wb = inflight - {3'b000, wb_hit};
        full              = (inflight_after_wb == INFLIGHT_MAX);

        issue_ready = !i_flush && !raw1 && !raw2 && !waw && !full;
        set_en      = i_issue_valid && issue_ready && i_issue_rd_we &&
                      (i_issue_rd != '0);

        busy_nxt   = busy;
        fwd_ok_nxt = fwd_ok;
        if (wb_hit) begin
            busy_nxt[i_wb_rd]   = 1'b0;
            fwd_ok_nxt[i_wb_rd] = 1'b0;
        end
        // Applied after the clear so a same-register issue wins over writeback.
        if (set_en) begin
            busy_nxt[i_issue_rd]   = 1'b1;
            fwd_ok_nxt[i_issue_rd] = (FWD_EN != 0) && rd_src_forwardable(i_issue_rd_src);
        end
        inflight_nxt = inflight_after_wb + {3'b000, set_en};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            busy     <= '0;
            fwd_ok   <= '0;
            inflight <= '0;
        end else begin
            busy     <= busy_nxt;
            fwd_ok   <= fwd_ok_nxt;
            inflight <= inflight_nxt;
        end
    end

    // Writebacks to x0 are legal no-ops and never flagged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_err <= 1'b0;
        end else begin
            o_wb_err <= wb_miss;
        end
    end

    assign o_issue_ready = issue_ready;
    assign o_busy        = busy;
    assign o_inflight    = inflight;

endmodule

// File: doc/core_scoreboard.md
Name: core_scoreboard

Overview:
- Register-hazard scheduler between decode and execute of the in-order core pipeline.
- Tracks every architectural register (x1..x31) that has an in-flight writer.
- Deasserts issue-ready on a RAW hazard that forwarding cannot cover, on any WAW hazard, or when the in-flight limit is reached.
- Clears entries on writeback and drops all state on pipeline flush.

Parameters:
- MAX_INFLIGHT, 4: maximum instructions with a pending rd write; range 1..15.
- FWD_EN, 1: when 1, a pending writer with rd_src RD_FROM_ALU_RESULT or RD_FROM_NEXT_SEQ_PC does not cause a RAW stall from the cycle after issue.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_issue_valid  in  1  decode presents an instruction.
- i_issue_rs1  in  5  rs1 index (reg_idx_t).
- i_issue_rs1_used  in  1  instruction reads rs1.
- i_issue_rs2  in  5  rs2 index (reg_idx_t).
- i_issue_rs2_used  in  1  instruction reads rs2.
- i_issue_rd_we  in  1  instruction writes rd.
- i_issue_rd  in  5  rd index (reg_idx_t).
- i_issue_rd_src  in  2  writeback source (rd_src_e).
- o_issue_ready  out  1  combinational; issue fires when i_issue_valid && o_issue_ready.
- i_wb_valid  in  1  writeback retires a register write.
- i_wb_rd  in  5  writeback rd index.
- i_flush  in  1  kill all in-flight instructions.
- o_busy  out  32  per-register pending bits; bit 0 is always 0.
- o_inflight  out  4  current count of pending writers.
- o_wb_err  out  1  registered one-cycle pulse: writeback hit a non-busy register.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: busy = 0, fwd_ok = 0, inflight = 0, o_wb_err = 0. o_issue_ready is 1 in the first cycle after reset.
- State per register r (1..31):
  - busy[r].
  - fwd_ok[r]: set at issue iff FWD_EN && rd_src in {ALU_RESULT, NEXT_SEQ_PC}.
- Effective busy, eff_busy[r] = busy[r] && !(i_wb_valid && i_wb_rd == r). This is the same-cycle writeback bypass.
- RAW hazard on rsN when all of the following hold:
  - rsN_used;
  - rsN != 0;
  - eff_busy[rsN];
  - !fwd_ok[rsN].
- WAW hazard when all of the following hold:
  - rd_we;
  - rd != 0;
  - eff_busy[rd]. fwd_ok does not waive WAW.
- Capacity full when inflight_after_wb == MAX_INFLIGHT, where inflight_after_wb = inflight minus 1 if a valid writeback hits a busy register.
- o_issue_ready = !i_flush && !RAW1 && !RAW2 && !WAW && !full. Ready is independent of i_issue_valid.
- On issue fire with rd_we && rd != 0:
  - set busy[rd]; load fwd_ok[rd];
  - inflight increments.
  - Issue with rd == 0 or !rd_we changes no state.
- On writeback to a busy register: clear busy and fwd_ok, inflight decrements.
- Writeback and issue in the same cycle:
  - Different registers: both take effect; inflight is net unchanged.
  - Same register: set wins, so busy = 1 with the new fwd_ok.
- Writeback to a non-busy register, or to x0 with i_wb_valid:
  - No state change.
  - o_wb_err pulses next cycle, except writes to x0, which are silently ignored.
- Flush:
  - Next cycle, all busy and fwd_ok = 0 and inflight = 0. Flush overrides any issue or writeback that cycle.
  - Writebacks arriving after a flush to now-clear registers raise o_wb_err. The pipeline guarantees killed instructions do not write back.
- fwd_ok takes effect the cycle after issue. Same-cycle forwarding is not modelled because a just-issued writer is never visible to the issuing instruction.
- Reset mid-operation: all state clears regardless of other inputs.
- No state machine beyond the per-register bits and the saturating-free counter. inflight never exceeds MAX_INFLIGHT by construction.

Decomposition:
- Add to core_pkg:
  - NUM_ARCH_REGS = 32;
  - function rd_src_forwardable(rd_src_e), returning 1 for ALU_RESULT and NEXT_SEQ_PC.
- Reuse the existing reg_idx_t and rd_src_e types.
- No sub-module; the hazard compare logic is inline.

Test Plan:
- Reset then idle -> o_issue_ready = 1, o_busy = 0, o_inflight = 0.
- Load issue rd = x5 (RD_FROM_MEM_LOAD), next cycle an instruction with rs1 = x5 -> ready = 0. Then wb x5 in that cycle -> ready = 1 the same cycle; issue fires; busy[5] = 0.
- FWD_EN = 1: ALU issue rd = x7, next cycle rs2 = x7 -> ready = 1. The same case with rd = x7 as WAW -> ready = 0.
- MAX_INFLIGHT = 4: issue to x1..x4 -> o_inflight = 4, fifth issue ready = 0. Same cycle add wb x1 -> ready = 1, o_inflight stays 4.
- Busy x3, x9 then i_flush with a concurrent issue to x10 -> next cycle o_busy = 0, o_inflight = 0, and x10 not set.
- wb x12 while not busy -> o_wb_err = 1 for exactly one cycle. wb x0 -> no pulse.
